spi_cmd_decoder: RTL and testbench



---
 rtl/spi_cmd_decoder_pkg.sv | 33 +++
 rtl/spi_cmd_decoder_cmd_fifo.sv | 72 +++++++
 rtl/spi_cmd_decoder.sv | 149 ++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_decoder_pkg.sv
// Shared types for the SPI command decoder: frame addresses, command opcodes
// and the command record carried through the command FIFO.
package spi_cmd_pkg;

  localparam logic [3:0] ADDR_NOP     = 4'h0;
  localparam logic [3:0] ADDR_CTRL    = 4'h1;
  localparam logic [3:0] ADDR_DROP    = 4'h2;
  localparam logic [3:0] ADDR_STEPCNT = 4'h3;
  localparam logic [3:0] ADDR_CLEAR   = 4'h4;
  localparam logic [3:0] ADDR_STEP    = 4'h5;
  localparam logic [3:0] ADDR_ID      = 4'hA;
  localparam logic [3:0] ADDR_CLRERR  = 4'hF;

  typedef enum logic [1:0] {
    OP_DROP  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_STEP  = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef struct packed {
    cmd_op_e     op;
    logic [11:0] arg;
  } cmd_t;

  function automatic cmd_t make_cmd(input cmd_op_e op, input logic [11:0] arg);
    cmd_t c;
    c.op  = op;
    c.arg = arg;
    return c;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_cmd_fifo.sv
// Small synchronous FIFO of cmd_t records. A push into a full FIFO is only
// taken when a pop happens in the same cycle; the caller sees full to flag loss.
module cmd_fifo
  import spi_cmd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic sys_clock,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic empty,
  output logic full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // The head reads as all-zero while empty so the core never sees stale data.
  assign head = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes completed SPI frames once each into register writes or queued core
// commands. Defining SPI_FRAME_CNT_EN adds the frame_count port and counter.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int CMD_DEPTH = 2,
  parameter int GRID_BITS = 6
) (
  input  logic        sys_clock,
  input  logic        rst_n,
  input  logic [3:0]  spi_address,
  input  logic [11:0] spi_data,
  input  logic        spi_is_ready,
  output logic [11:0] ctrl_reg,
  output logic [11:0] step_target,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_op,
  output logic [11:0] cmd_arg,
  output logic        err_overflow,
  output logic        err_bad_addr
`ifdef SPI_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_count
`endif
);

  localparam int          ARG_BITS = 2 * GRID_BITS;
  localparam logic [11:0] ARG_MASK = 12'((1 << ARG_BITS) - 1);

  logic        rdy_q, rdy_d;
  logic [11:0] ctrl_q, ctrl_d;
  logic [11:0] step_q, step_d;
  logic        err_ovf_q, err_ovf_d;
  logic        err_bad_q, err_bad_d;
  logic        accept;
  logic        push;
  cmd_t        push_cmd;
  logic        pop;
  logic        overflow;
  logic        set_bad;
  logic        clr_err;
  cmd_t        head;
  logic        fifo_empty;
  logic        fifo_full;

  // The ready level stays high until SS rises, so only its rising edge counts.
  assign rdy_d  = spi_is_ready;
  assign accept = spi_is_ready & ~rdy_q;

  always_comb begin
    ctrl_d   = ctrl_q;
    step_d   = step_q;
    push     = 1'b0;
    push_cmd = '0;
    set_bad  = 1'b0;
    clr_err  = 1'b0;
    if (accept) begin
      case (spi_address)
        ADDR_NOP, ADDR_ID: begin
        end
        ADDR_CTRL:    ctrl_d = spi_data;
        ADDR_STEPCNT: step_d = spi_data;
        ADDR_DROP: begin
          push     = 1'b1;
          push_cmd = make_cmd(OP_DROP, spi_data & ARG_MASK);
        end
        ADDR_CLEAR: begin
          push     = 1'b1;
          push_cmd = make_cmd(OP_CLEAR, 12'h000);
        end
        ADDR_STEP: begin
          // Single steps are only meaningful in step mode; otherwise drop quietly.
          if (ctrl_q[1]) begin
            push     = 1'b1;
            push_cmd = make_cmd(OP_STEP, 12'h000);
          end
        end
        ADDR_CLRERR:  clr_err = 1'b1;
        default:      set_bad = 1'b1;
      endcase
    end
  end

  assign pop      = ~fifo_empty & cmd_ready;
  assign overflow = push & fifo_full & ~pop;

  // Clearing happens first so that a simultaneous new error still sticks.
  always_comb begin
    err_ovf_d = clr_err ? 1'b0 : err_ovf_q;
    err_bad_d = clr_err ? 1'b0 : err_bad_q;
    if (overflow) err_ovf_d = 1'b1;
    if (set_bad)  err_bad_d = 1'b1;
  end

  always_ff @(posedge sys_clock) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      ctrl_q    <= '0;
      step_q    <= '0;
      err_ovf_q <= 1'b0;
      err_bad_q <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      ctrl_q    <= ctrl_d;
      step_q    <= step_d;
      err_ovf_q <= err_ovf_d;
      err_bad_q <= err_bad_d;
    end
  end

  cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_cmd_fifo (
    .sys_clock (sys_clock),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef SPI_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = accept ? frame_cnt_q + 8'd1 : frame_cnt_q;

  always_ff @(posedge sys_clock) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

  assign ctrl_reg     = ctrl_q;
  assign step_target  = step_q;
  assign cmd_valid    = ~fifo_empty;
  assign cmd_op       = head.op;
  assign cmd_arg      = head.arg;
  assign err_overflow = err_ovf_q;
  assign err_bad_addr = err_bad_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Randomised and directed checks of spi_cmd_decoder against a queue-based
// model of the frame decoding rules.
module tb_spi_cmd_decoder;

  localparam int DEPTH = 2;
  localparam int GRID  = 6;

  logic        sys_clock;
  logic        rst_n;
  logic [3:0]  spi_address;
  logic [11:0] spi_data;
  logic        spi_is_ready;
  logic [11:0] ctrl_reg;
  logic [11:0] step_target;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [11:0] cmd_arg;
  logic        err_overflow;
  logic        err_bad_addr;
`ifdef SPI_FRAME_CNT_EN
  logic [7:0]  frame_count;
`endif

  spi_cmd_decoder #(
    .CMD_DEPTH(DEPTH),
    .GRID_BITS(GRID)
  ) dut (
    .sys_clock    (sys_clock),
    .rst_n        (rst_n),
    .spi_address  (spi_address),
    .spi_data     (spi_data),
    .spi_is_ready (spi_is_ready),
    .ctrl_reg     (ctrl_reg),
    .step_target  (step_target),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .err_overflow (err_overflow),
    .err_bad_addr (err_bad_addr)
`ifdef SPI_FRAME_CNT_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  int total = 0;
  int bad   = 0;
  int ready_mode = 1;

  // Reference state: queue of {op, arg} entries plus the visible registers.
  logic [13:0] mq[$];
  logic [11:0] m_ctrl, m_step;
  logic        m_eo, m_eb, m_rdy;
  logic [7:0]  m_fc;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic pickReady();
    if (ready_mode == 2) return 1'($urandom_range(0, 1));
    return (ready_mode == 1);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    logic        acc, do_pop, push, full;
    logic [13:0] entry;
    logic        clr, set_eo, set_eb;
    if (!rst_n) begin
      mq.delete();
      m_ctrl = 0; m_step = 0; m_eo = 0; m_eb = 0; m_rdy = 0; m_fc = 0;
      return;
    end
    acc    = spi_is_ready && !m_rdy;
    m_rdy  = spi_is_ready;
    do_pop = (mq.size() > 0) && cmd_ready;
    full   = (mq.size() == DEPTH);
    push = 0; entry = 0; clr = 0; set_eo = 0; set_eb = 0;
    if (acc) begin
      m_fc = m_fc + 8'd1;
      case (spi_address)
        4'h0, 4'hA: ;
        4'h1: m_ctrl = spi_data;
        4'h2: begin push = 1; entry = {2'd0, spi_data & 12'((1 << (2 * GRID)) - 1)}; end
        4'h3: m_step = spi_data;
        4'h4: begin push = 1; entry = {2'd1, 12'h000}; end
        4'h5: if (m_ctrl[1]) begin push = 1; entry = {2'd2, 12'h000}; end
        4'hF: clr = 1;
        default: set_eb = 1;
      endcase
    end
    if (do_pop) void'(mq.pop_front());
    if (push) begin
      if (full && !do_pop) set_eo = 1;
      else mq.push_back(entry);
    end
    if (clr) begin m_eo = 0; m_eb = 0; end
    if (set_eo) m_eo = 1;
    if (set_eb) m_eb = 1;
  endtask

  task automatic compareAll();
    logic        e_valid;
    logic [13:0] e_head;
    e_valid = (mq.size() > 0);
    e_head  = e_valid ? mq[0] : 14'h0;
    checkOutput("cmd_valid", cmd_valid, e_valid);
    checkOutput("cmd_op", cmd_op, e_head[13:12]);
    checkOutput("cmd_arg", cmd_arg, e_head[11:0]);
    checkOutput("ctrl_reg", ctrl_reg, m_ctrl);
    checkOutput("step_target", step_target, m_step);
    checkOutput("err_overflow", err_overflow, m_eo);
    checkOutput("err_bad_addr", err_bad_addr, m_eb);
`ifdef SPI_FRAME_CNT_EN
    checkOutput("frame_count", frame_count, m_fc);
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, then check after the next rising edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [11:0] d, input logic r);
    spi_address  = a;
    spi_data     = d;
    spi_is_ready = r;
    cmd_ready    = pickReady();
    modelStep();
    @(posedge sys_clock);
    @(negedge sys_clock);
    compareAll();
  endtask

  task automatic sendFrame(input logic [3:0] a, input logic [11:0] d, input int hold, input int gap);
    for (int i = 0; i < hold; i++) applyStimulus(a, d, 1'b1);
    for (int i = 0; i < gap; i++) applyStimulus(a, d, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    spi_address = 0; spi_data = 0; spi_is_ready = 0; cmd_ready = 0;
    m_ctrl = 0; m_step = 0; m_eo = 0; m_eb = 0; m_rdy = 0; m_fc = 0;

    ready_mode = 1;
    applyStimulus(4'h0, 12'h000, 1'b0);
    applyStimulus(4'h0, 12'h000, 1'b0);
    checkOutput("rst_valid", cmd_valid, 1'b0);
    checkOutput("rst_ctrl", ctrl_reg, 12'h000);
    rst_n = 1'b1;

    // CTRL held for ten cycles is decoded once.
    applyStimulus(4'h1, 12'h003, 1'b1);
    checkOutput("ctrl_first", ctrl_reg, 12'h003);
    sendFrame(4'h1, 12'h003, 9, 1);
    checkOutput("ctrl_held", ctrl_reg, 12'h003);

    // DROP with the core ready is visible for exactly one cycle.
    applyStimulus(4'h2, 12'h2A5, 1'b1);
    checkOutput("drop_valid", cmd_valid, 1'b1);
    checkOutput("drop_arg", cmd_arg, 12'h2A5);
    applyStimulus(4'h2, 12'h2A5, 1'b0);
    checkOutput("drop_once", cmd_valid, 1'b0);

    // Three DROPs into a stalled FIFO: the third is lost.
    ready_mode = 0;
    sendFrame(4'h2, 12'h001, 1, 1);
    sendFrame(4'h2, 12'h002, 1, 1);
    sendFrame(4'h2, 12'h003, 1, 1);
    checkOutput("ovf_set", err_overflow, 1'b1);
    checkOutput("ovf_head", cmd_arg, 12'h001);
    ready_mode = 1;
    applyStimulus(4'h0, 12'h000, 1'b0);
    checkOutput("ovf_second", cmd_arg, 12'h002);
    applyStimulus(4'h0, 12'h000, 1'b0);
    checkOutput("ovf_drained", cmd_valid, 1'b0);
    sendFrame(4'hF, 12'h000, 1, 1);
    checkOutput("ovf_cleared", err_overflow, 1'b0);

    // STEP is ignored until step mode is enabled.
    ready_mode = 0;
    sendFrame(4'h1, 12'h000, 1, 1);
    sendFrame(4'h5, 12'h000, 1, 1);
    checkOutput("step_ignored", cmd_valid, 1'b0);
    sendFrame(4'h1, 12'h002, 1, 1);
    sendFrame(4'h5, 12'h000, 1, 1);
    checkOutput("step_op", cmd_op, 2'd2);
    ready_mode = 1;
    applyStimulus(4'h0, 12'h000, 1'b0);

    // ID is a silent NOP; a reserved address raises the sticky flag.
    sendFrame(4'hA, 12'h000, 2, 1);
    checkOutput("id_no_err", err_bad_addr, 1'b0);
    sendFrame(4'h7, 12'h000, 2, 1);
    checkOutput("bad_addr", err_bad_addr, 1'b1);

    // Reset with a full FIFO and the ready level already high at release.
    ready_mode = 0;
    sendFrame(4'h2, 12'h011, 1, 1);
    sendFrame(4'h2, 12'h022, 1, 1);
    rst_n = 1'b0;
    applyStimulus(4'h2, 12'h155, 1'b1);
    checkOutput("flush_valid", cmd_valid, 1'b0);
    checkOutput("flush_err", err_bad_addr, 1'b0);
    rst_n = 1'b1;
    applyStimulus(4'h2, 12'h155, 1'b1);
    checkOutput("post_rst_arg", cmd_arg, 12'h155);
    ready_mode = 1;
    sendFrame(4'h2, 12'h155, 2, 1);

    // Randomised frames with random back-pressure and occasional resets.
    ready_mode = 2;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        applyStimulus(4'($urandom), 12'($urandom), 1'($urandom_range(0, 1)));
        rst_n = 1'b1;
      end
      sendFrame(4'($urandom), 12'($urandom), $urandom_range(1, 4), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
